// File: rtl/seq_shift_add_mult_if.sv
// Handshake bundle for seq_shift_add_mult.
// Operand side: in_valid/in_ready, a, b (plus sgn when SEQ_MULT_SIGNED_EN is defined).
// Result side:  out_valid/out_ready, product; busy is a status flag.
// master = operand producer / result consumer, slave = multiplier.
interface seq_shift_add_mult_if #(
  parameter int unsigned WIDTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
`ifdef SEQ_MULT_SIGNED_EN
  logic                   sgn;

  modport master (output in_valid, a, b, sgn, out_ready,
                  input  in_ready, out_valid, product, busy);
  modport slave  (input  in_valid, a, b, sgn, out_ready,
                  output in_ready, out_valid, product, busy);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, product, busy);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, product, busy);
`endif
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial
// product per clock. Optional macro SEQ_MULT_SIGNED_EN adds a sgn input that
// selects two's complement operands (sign-magnitude around the unsigned core).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of seq_shift_add_mult_if (operands, product, busy)
module seq_shift_add_mult #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_shift_add_mult_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [PW-1:0]    product_q;

  // Operand magnitudes and final result as seen by the unsigned core
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [PW-1:0]    result_c;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q;
  logic neg_c;

  // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
  always_comb begin
    a_mag_c  = (bus.sgn && bus.a[WIDTH-1]) ? WIDTH'(~bus.a + 1'b1) : bus.a;
    b_mag_c  = (bus.sgn && bus.b[WIDTH-1]) ? WIDTH'(~bus.b + 1'b1) : bus.b;
    neg_c    = bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    result_c = neg_q ? PW'(~acc + 1'b1) : acc;
  end
`else
  always_comb begin
    a_mag_c  = bus.a;
    b_mag_c  = bus.b;
    result_c = acc;
  end
`endif

  // Control FSM and datapath; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            mcand      <= PW'(a_mag_c);
            mplier     <= b_mag_c;
            acc        <= '0;
            cnt        <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q      <= neg_c;
`endif
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          // WIDTH accumulate edges, then one edge to publish the result
          if (cnt == CNT_W'(WIDTH)) begin
            product_q   <= result_c;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: the driver pushes expected products
// (plain integer multiplication) into a queue, a negedge monitor pops and
// compares on each output handshake.
module tb_seq_shift_add_mult;
  parameter int unsigned W = 4;
  localparam int unsigned PW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_shift_add_mult_if #(.WIDTH(W)) bus ();

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  int            cyc     = 0;
  logic [PW-1:0] exp_q[$];
  int            acc_q[$];
  logic          ov_prev = 1'b0;
  logic          hs_prev = 1'b0;
  logic          rand_rdy = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: integer product of the operands as interpreted by sgn
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    longint px, py;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    return PW'(px * py);
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
`ifdef SEQ_MULT_SIGNED_EN
    bus.sgn = s;
`endif
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(model(x, y, s));
    acc_q.push_back(cyc);
    // Operands after acceptance must be ignored
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    bus.out_ready = r;
  endtask

  // Random backpressure, changed away from the negedge sampling point
  always @(posedge clk) if (rand_rdy) #1 bus.out_ready = 1'($urandom_range(0, 1));

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_prev) begin
        check("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
        check("out_valid_after_hs", 64'(bus.out_valid), 64'd0);
      end
      hs_prev = 1'b0;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          if (!ov_prev) check("latency", 64'(cyc - acc_q[0]), 64'(W + 1));
          check("product", 64'(bus.product), 64'(exp_q[0]));
          check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
          check("busy_in_done", 64'(bus.busy), 64'd1);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            hs_prev = 1'b1;
          end
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    logic s;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    bus.sgn       = 1'b0;
`endif
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed products, including a zero multiplicand
    send(W'(13), W'(11), 1'b0);
    drain();
    send(W'(15), W'(15), 1'b0);
    send(W'(0),  W'(9),  1'b0);
    send(W'(13), W'(3),  1'b0);
    send('1, '1, 1'b0);
    send(W'(200), W'(3), 1'b0);
    drain();

    // Backpressure: result must hold while out_ready is low
    set_ready(1'b0);
    send(W'(7), W'(6), 1'b0);
    begin
      int t = 0;
      while (!bus.out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
    end
    repeat (10) @(negedge clk);
    set_ready(1'b1);
    drain();

    // Reset in the middle of CALC discards the operation
    send(W'(9), W'(9), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    ov_prev = 1'b0;
    hs_prev = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_product", 64'(bus.product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      check("post_rst_no_out_valid", 64'(bus.out_valid), 64'd0);
    end
    send(W'(3), W'(5), 1'b0);
    drain();

`ifdef SEQ_MULT_SIGNED_EN
    // Signed cases: -3x5, most-negative squared, 7x-1, and unsigned mode
    send(W'(-3), W'(5), 1'b1);
    send(W'(1) << (W - 1), W'(1) << (W - 1), 1'b1);
    send(W'(7), W'(-1), 1'b1);
    send(W'(13), W'(3), 1'b0);
    drain();
`endif

    // Random operands with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = W'($urandom);
      y = W'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      send(x, y, s);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    set_ready(1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
